// File: rtl/uart_dbg_pkg.sv
// uart_dbg_pkg: opcodes, reply codes and state enums
// shared by the debug UART bridge and its serial phy.
package uart_dbg_pkg;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] OP_PING  = 8'h50;
  localparam logic [7:0] RSP_ACK  = 8'h06;
  localparam logic [7:0] RSP_NAK  = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_BUS,
    ST_REPLY
  } state_e;

  typedef enum logic [1:0] {
    RX_HUNT,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_dbg_phy.sv
// uart_dbg_phy: 8N1 receive and transmit engines with
// a byte-level strobe interface, CLK_DIV clocks per bit.
module uart_dbg_phy
  import uart_dbg_pkg::*;
#(
  parameter int CLK_DIV = 104
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ser_rx,
  output logic       ser_tx,
  output logic       rx_strobe,
  output logic       rx_err,
  output logic [7:0] rx_byte,
  input  logic       tx_start,
  input  logic [7:0] tx_byte,
  output logic       tx_idle
);

  localparam logic [15:0] BIT_END  = 16'(CLK_DIV - 1);
  localparam logic [15:0] HALF_END = 16'(CLK_DIV / 2 - 1);

  rx_state_e   r_rx_st, w_rx_nxt;
  logic        r_rx_prev;
  logic [15:0] r_rx_cnt;
  logic [2:0]  r_rx_idx;
  logic [7:0]  r_rx_sh;
  logic [15:0] w_rx_lim;
  logic        w_rx_tick;

  assign w_rx_lim  = (r_rx_st == RX_START) ? HALF_END : BIT_END;
  assign w_rx_tick = (r_rx_cnt == w_rx_lim);

  always_comb begin
    w_rx_nxt = r_rx_st;
    unique case (r_rx_st)
      RX_HUNT:  if (r_rx_prev && !ser_rx) w_rx_nxt = RX_START;
      RX_START: if (w_rx_tick) w_rx_nxt = ser_rx ? RX_HUNT : RX_DATA;
      RX_DATA:  if (w_rx_tick && r_rx_idx == 3'd7) w_rx_nxt = RX_STOP;
      RX_STOP:  if (w_rx_tick) w_rx_nxt = RX_HUNT;
      default:  w_rx_nxt = RX_HUNT;
    endcase
  end

  assign rx_strobe = (r_rx_st == RX_STOP) && w_rx_tick && ser_rx;
  assign rx_err    = (r_rx_st == RX_STOP) && w_rx_tick && !ser_rx;
  assign rx_byte   = r_rx_sh;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_st <= RX_HUNT;
    end else begin
      r_rx_st <= w_rx_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_prev <= 1'b1;
      r_rx_cnt  <= '0;
      r_rx_idx  <= '0;
      r_rx_sh   <= '0;
    end else begin
      r_rx_prev <= ser_rx;
      if (r_rx_st == RX_HUNT || w_rx_tick) r_rx_cnt <= '0;
      else r_rx_cnt <= r_rx_cnt + 16'd1;
      if (r_rx_st == RX_DATA && w_rx_tick) begin
        r_rx_idx <= r_rx_idx + 3'd1;
        r_rx_sh  <= {ser_rx, r_rx_sh[7:1]};
      end
    end
  end

  logic        r_tx_busy;
  logic [15:0] r_tx_cnt;
  logic [3:0]  r_tx_idx;
  logic [9:0]  r_tx_sh;

  assign tx_idle = !r_tx_busy;
  assign ser_tx  = !r_tx_busy || r_tx_sh[0];

  // frame is {stop, data, start}, shifted out LSB first
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_busy <= 1'b0;
      r_tx_cnt  <= '0;
      r_tx_idx  <= '0;
      r_tx_sh   <= '1;
    end else if (!r_tx_busy) begin
      if (tx_start) begin
        r_tx_busy <= 1'b1;
        r_tx_cnt  <= '0;
        r_tx_idx  <= '0;
        r_tx_sh   <= {1'b1, tx_byte, 1'b0};
      end
    end else if (r_tx_cnt == BIT_END) begin
      r_tx_cnt <= '0;
      r_tx_sh  <= {1'b1, r_tx_sh[9:1]};
      r_tx_idx <= r_tx_idx + 4'd1;
      if (r_tx_idx == 4'd9) r_tx_busy <= 1'b0;
    end else begin
      r_tx_cnt <= r_tx_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/uart_dbg_bridge.sv
// uart_dbg_bridge: UART command parser driving one bus word access.
// Define UART_DBG_TIMEOUT_EN to abandon stalled partial frames.
module uart_dbg_bridge
  import uart_dbg_pkg::*;
#(
  parameter int CLK_DIV      = 104,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ser_rx,
  output logic        ser_tx,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  logic       w_rx_stb, w_rx_err, w_tx_idle, w_tx_start;
  logic [7:0] w_rx_byte, w_tx_byte;
  logic       w_to_hit, w_last;

  uart_dbg_phy #(.CLK_DIV(CLK_DIV)) u_phy (
    .clk       (clk),
    .reset     (reset),
    .ser_rx    (ser_rx),
    .ser_tx    (ser_tx),
    .rx_strobe (w_rx_stb),
    .rx_err    (w_rx_err),
    .rx_byte   (w_rx_byte),
    .tx_start  (w_tx_start),
    .tx_byte   (w_tx_byte),
    .tx_idle   (w_tx_idle)
  );

  state_e      r_state, w_next;
  logic [1:0]  r_cnt;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [7:0]  r_rsp;
  logic        r_is_wr, r_is_rd, r_valid;

  assign mem_valid = r_valid;
  assign mem_addr  = r_addr & 32'hFFFF_FFFC;
  assign mem_wdata = r_wdata;
  assign mem_wstrb = r_is_wr ? 4'hF : 4'h0;
  assign busy      = (r_state != ST_IDLE);

  always_comb begin
    w_next     = r_state;
    w_tx_start = 1'b0;
    w_tx_byte  = r_is_rd ? r_rdata[{r_cnt, 3'b000} +: 8] : r_rsp;
    w_last     = !r_is_rd || (r_cnt == 2'd3);
    unique case (r_state)
      ST_IDLE:
        if (w_rx_stb)
          w_next = (w_rx_byte == OP_WRITE || w_rx_byte == OP_READ)
                   ? ST_ADDR : ST_REPLY;
      ST_ADDR:
        if (w_rx_err || w_to_hit) w_next = ST_IDLE;
        else if (w_rx_stb && r_cnt == 2'd3)
          w_next = r_is_wr ? ST_DATA : ST_BUS;
      ST_DATA:
        if (w_rx_err || w_to_hit) w_next = ST_IDLE;
        else if (w_rx_stb && r_cnt == 2'd3) w_next = ST_BUS;
      ST_BUS:
        if (mem_ready && r_valid) w_next = ST_REPLY;
      ST_REPLY:
        if (w_tx_idle) begin
          w_tx_start = 1'b1;
          if (w_last) w_next = ST_IDLE;
        end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_rsp   <= '0;
      r_is_wr <= 1'b0;
      r_is_rd <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= (w_next == ST_BUS);
      if (w_next != r_state) r_cnt <= '0;
      else if (w_tx_start || (w_rx_stb &&
               (r_state == ST_ADDR || r_state == ST_DATA)))
        r_cnt <= r_cnt + 2'd1;
      if (r_state == ST_IDLE && w_rx_stb) begin
        r_is_wr <= (w_rx_byte == OP_WRITE);
        r_is_rd <= (w_rx_byte == OP_READ);
        r_rsp   <= (w_rx_byte == OP_WRITE || w_rx_byte == OP_PING)
                   ? RSP_ACK : RSP_NAK;
      end
      if (r_state == ST_ADDR && w_rx_stb)
        r_addr[{r_cnt, 3'b000} +: 8] <= w_rx_byte;
      if (r_state == ST_DATA && w_rx_stb)
        r_wdata[{r_cnt, 3'b000} +: 8] <= w_rx_byte;
      if (r_state == ST_BUS && mem_ready && r_valid)
        r_rdata <= mem_rdata;
    end
  end

`ifdef UART_DBG_TIMEOUT_EN
  localparam int TO_LIM = TIMEOUT_BITS * CLK_DIV;
  localparam int TO_W   = $clog2(TO_LIM + 1);

  logic [TO_W-1:0] r_to;

  assign w_to_hit = (r_to == TO_W'(TO_LIM));

  always_ff @(posedge clk) begin
    if (reset) r_to <= '0;
    else if (w_rx_stb || !(r_state == ST_ADDR || r_state == ST_DATA))
      r_to <= '0;
    else if (!w_to_hit)
      r_to <= r_to + TO_W'(1);
  end
`else
  // partial frames wait forever
  assign w_to_hit = (TIMEOUT_BITS < 0);
`endif

endmodule
